hazard_unit: RTL and testbench
==============================

# hazard_unit

- Pipeline hazard controller for the five-stage pipelined core.
- Consumes the Execute-stage control and register-address bundle produced by the Decode→Execute pipeline registers.
- Keeps its own Memory/Writeback shadow of destination registers.
- Drives forwarding selects, plus stall/flush back into the Fetch, Decode and Execute pipeline registers, closing the loop on those registers.
- Also counts stall and flush cycles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall/flush cycle counters

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- Rs1_D  input  5  source register 1 of instruction in Decode
- Rs2_D  input  5  source register 2 of instruction in Decode
- Rs1_E  input  5  source register 1 of instruction in Execute
- Rs2_E  input  5  source register 2 of instruction in Execute
- Rd_E  input  5  destination register of instruction in Execute
- RegWrite_E  input  1  Execute instruction writes register file
- ResultSrc_E  input  2  Execute result source; 2'b01 = data memory (load)
- PCSrc_E  input  1  taken branch or jump resolved in Execute
- ForwardA_E  output  2  ALU operand A select: 00 regfile, 01 Writeback result, 10 Memory ALU result
- ForwardB_E  output  2  ALU operand B select, same encoding
- Stall_F  output  1  hold PC register
- Stall_D  output  1  hold Fetch→Decode register
- Flush_D  output  1  clear Fetch→Decode register to bubble
- Flush_E  output  1  clear Decode→Execute register to bubble
- StallCount  output  CNT_W  saturating count of cycles with Stall_D=1
- FlushCount  output  CNT_W  saturating count of cycles with PCSrc_E=1

## Operation
- Shadow pipeline updates every clock; stalls never freeze it, because Execute is bubbled, not held.
  - Rd_M<=Rd_E, RegWrite_M<=RegWrite_E.
  - Rd_W<=Rd_M, RegWrite_W<=RegWrite_M.
- Register x0 never matches: any comparison with Rd==0 is false.
- Forwarding, per operand, priority M over W:
  - 10 if Rs_E==Rd_M and RegWrite_M.
  - else 01 if Rs_E==Rd_W and RegWrite_W.
  - else 00.
- Load-use stall: lwStall = (ResultSrc_E==2'b01) and RegWrite_E and Rd_E!=0 and (Rs1_D==Rd_E or Rs2_D==Rd_E).
- Stall_F=Stall_D = lwStall and not PCSrc_E. On a redirect the Decode instruction is dead, so the redirect wins.
- Flush_D = PCSrc_E.
- Flush_E = lwStall or PCSrc_E.
- Counters increment by 1 per qualifying cycle and saturate at all-ones; they never wrap.
- Writeback→Decode hazards need no action: the register file writes on the falling edge.

## Timing
- Forward/stall/flush outputs are combinational from inputs and shadow registers; there is no added latency.
- Load-use costs exactly one stall cycle. The next cycle the load is in M, the shadow has Rd_M=load Rd, and forwarding selects 01 one cycle later from W.
- Taken branch costs two bubbles (Decode and Execute flushed in the same cycle).
- Reset, asynchronously:
  - All shadow registers and counters go to 0.
  - While reset=1, all control outputs are forced to 0.
- Reset mid-stall: stall drops immediately; there is no residual state.
- PCSrc_E and lwStall in the same cycle:
  - Stall_F=Stall_D=0, Flush_D=1, Flush_E=1.
  - StallCount does not increment; FlushCount does.

## Configuration
- Macro HAZARD_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - ForwardA_E/ForwardB_E are tied to 00.
  - Stall condition becomes any RAW of Rs1_D/Rs2_D against (Rd_E, RegWrite_E) or (Rd_M, RegWrite_M), x0 excluded, regardless of ResultSrc_E.
  - Stall persists cycle by cycle until the producer reaches W: up to two cycles.
  - Flush_E = stall or PCSrc_E.
  - Redirect priority and counters are unchanged.

## Structure
- Shared package holds:
  - Forward-select typedef (FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - RESULT_SRC_MEM=2'b01.
  - Register-address width constant (5).
- One sub-module, sat_counter (parameter width, inc input, asynchronous reset), instantiated twice.
- Shadow pipeline and hazard logic stay in hazard_unit.

## Test plan
- Rd_E=5, RegWrite_E=1, ResultSrc_E=00, next cycle Rs1_E=5 → ForwardA_E=10; the cycle after, with Rs2_E=5 → ForwardB_E=01.
- Load in E, ResultSrc_E=01, Rd_E=7, Rs2_D=7 → Stall_F=Stall_D=Flush_E=1 for exactly one cycle, StallCount 0→1; with Rd_E=0 → no stall.
- PCSrc_E=1 together with a load-use match → Stall_D=0, Flush_D=Flush_E=1, FlushCount+1, StallCount unchanged.
- Preload StallCount near all-ones (CNT_W=4), then 20 stall cycles → holds at 15.
- Assert reset during a stall cycle → all outputs 0 immediately, counters 0, Rd_M/Rd_W cleared so no forward on the next cycle.
- Build without HAZARD_FORWARDING_EN, ALU producer Rd_E=3, Rs1_D=3 → two consecutive stall cycles, then release; Forward outputs always 00.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W           : register-address width (5 bits, x0..x31)
//   RESULT_SRC_MEM  : ResultSrc encoding for "result comes from data memory"
//   fwd_sel_t       : ALU operand forward select
//   raw_match       : read-after-write comparison with x0 excluded
//   fwd_select      : per-operand forward select, Memory beats Writeback
package hazard_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    // x0 is hard-wired zero, so a producer writing x0 never creates a hazard.
    function automatic logic raw_match(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd,
        input logic             wr
    );
        return wr && (rd != '0) && (rs == rd);
    endfunction

    // The Memory-stage producer is younger than the Writeback one, so it wins.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             wr_m,
        input logic [REG_W-1:0] rd_w,
        input logic             wr_w
    );
        if (raw_match(rs, rd_m, wr_m)) begin
            return FWD_M;
        end
        if (raw_match(rs, rd_w, wr_w)) begin
            return FWD_W;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
//   clk   : clock, counts on rising edge
//   reset : asynchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core.
// Tracks the destination registers of the instructions now in Memory and
// Writeback (shadow pipeline fed from the Execute bundle), and from those
// drives ALU forwarding selects plus stall/flush of the Fetch, Decode and
// Execute pipeline registers. Stall and redirect cycles are counted.
//
// Build option HAZARD_FORWARDING_EN:
//   defined   : forwarding from M/W, stall only on load-use (one cycle)
//   undefined : no forwarding (selects tied to 00); Decode stalls on any RAW
//               against Execute or Memory producers until the producer
//               reaches Writeback (up to two cycles)
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   Rs1_D, Rs2_D          : Decode source registers
//   Rs1_E, Rs2_E, Rd_E    : Execute source/destination registers
//   RegWrite_E            : Execute instruction writes the register file
//   ResultSrc_E           : Execute result source (01 = load)
//   PCSrc_E               : taken branch/jump resolved in Execute
//   ForwardA_E/ForwardB_E : ALU operand selects (00 reg, 01 W, 10 M)
//   Stall_F, Stall_D      : hold PC / Fetch->Decode register
//   Flush_D, Flush_E      : bubble Fetch->Decode / Decode->Execute register
//   StallCount            : saturating count of Stall_D cycles
//   FlushCount            : saturating count of PCSrc_E cycles
import hazard_unit_pkg::*;

module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1_D,
    input  logic [REG_W-1:0] Rs2_D,
    input  logic [REG_W-1:0] Rs1_E,
    input  logic [REG_W-1:0] Rs2_E,
    input  logic [REG_W-1:0] Rd_E,
    input  logic             RegWrite_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Shadow pipeline. It advances every cycle even while Decode stalls,
    // because a stall inserts a bubble into Execute rather than holding it.
    logic [REG_W-1:0] rd_m_reg;
    logic [REG_W-1:0] rd_w_reg;
    logic             reg_write_m_reg;
    logic             reg_write_w_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_m_reg        <= '0;
            rd_w_reg        <= '0;
            reg_write_m_reg <= 1'b0;
            reg_write_w_reg <= 1'b0;
        end else begin
            rd_m_reg        <= Rd_E;
            reg_write_m_reg <= RegWrite_E;
            rd_w_reg        <= rd_m_reg;
            reg_write_w_reg <= reg_write_m_reg;
        end
    end

    // Per-source RAW detection for the instruction in Decode.
    logic [REG_W-1:0] rs_d [2];
    logic [1:0]       hit_e;
`ifndef HAZARD_FORWARDING_EN
    logic [1:0]       hit_m;
`endif

    assign rs_d[0] = Rs1_D;
    assign rs_d[1] = Rs2_D;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit_e[gi] = raw_match(rs_d[gi], Rd_E, RegWrite_E);
`ifndef HAZARD_FORWARDING_EN
            assign hit_m[gi] = raw_match(rs_d[gi], rd_m_reg, reg_write_m_reg);
`endif
        end
    endgenerate

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     hazard;

`ifdef HAZARD_FORWARDING_EN
    assign fwd_a  = fwd_select(Rs1_E, rd_m_reg, reg_write_m_reg, rd_w_reg, reg_write_w_reg);
    assign fwd_b  = fwd_select(Rs2_E, rd_m_reg, reg_write_m_reg, rd_w_reg, reg_write_w_reg);
    // Only a load cannot be forwarded in time; everything else comes from M/W.
    assign hazard = (ResultSrc_E == RESULT_SRC_MEM) && (|hit_e);
`else
    assign fwd_a  = FWD_REG;
    assign fwd_b  = FWD_REG;
    // Without forwarding, Decode waits until the producer reaches Writeback;
    // the register file writes on the falling edge, so W needs no stall.
    assign hazard = (|hit_e) || (|hit_m);

    // Execute sources, result source and the Writeback shadow only matter
    // for forwarding; fold them into one sink so they are visibly unused.
    logic unused_fwd_only;
    assign unused_fwd_only = ^{Rs1_E, Rs2_E, ResultSrc_E, rd_w_reg, reg_write_w_reg};
`endif

    // A redirect kills the Decode instruction, so there is nothing to hold.
    logic stall;
    assign stall = hazard && !PCSrc_E;

    // Control outputs are held low for the whole time reset is asserted.
    assign ForwardA_E = reset ? FWD_REG : fwd_a;
    assign ForwardB_E = reset ? FWD_REG : fwd_b;
    assign Stall_F    = !reset && stall;
    assign Stall_D    = !reset && stall;
    assign Flush_D    = !reset && PCSrc_E;
    assign Flush_E    = !reset && (hazard || PCSrc_E);

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (Stall_D),
        .count (StallCount)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCSrc_E),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0, Rd_E = '0;
    logic             RegWrite_E = 1'b0;
    logic [1:0]       ResultSrc_E = 2'b00;
    logic             PCSrc_E = 1'b0;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             Stall_F, Stall_D, Flush_D, Flush_E;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1_D       (Rs1_D),
        .Rs2_D       (Rs2_D),
        .Rs1_E       (Rs1_E),
        .Rs2_E       (Rs2_E),
        .Rd_E        (Rd_E),
        .RegWrite_E  (RegWrite_E),
        .ResultSrc_E (ResultSrc_E),
        .PCSrc_E     (PCSrc_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .Flush_E     (Flush_E),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    // Reference model: list of earlier Execute producers, newest first
    // (entry 0 is now in Memory, entry 1 in Writeback), plus counter totals.
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
    } prod_t;

    prod_t hist[$];
    int    model_stalls = 0;
    int    model_flushes = 0;
    int    checks = 0;
    int    errors = 0;
    int    cycle_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    function automatic bit writes(input prod_t p, input logic [4:0] rs);
        return p.wr && p.rd != 5'd0 && p.rd == rs;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (writes(hist[k], rs)) sel = (k == 0) ? 2'b10 : 2'b01;
        end
        return FWD_EN ? sel : 2'b00;
    endfunction

    function automatic bit exp_hazard();
        prod_t e;
        bit    hit_e, hit_m;
        e     = '{rd: Rd_E, wr: RegWrite_E};
        hit_e = writes(e, Rs1_D) || writes(e, Rs2_D);
        hit_m = hist.size() > 0 && (writes(hist[0], Rs1_D) || writes(hist[0], Rs2_D));
        if (FWD_EN) return hit_e && ResultSrc_E == 2'b01;
        return hit_e || hit_m;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Called at each rising edge, before inputs change.
    task automatic model_edge();
        if (reset) begin
            hist.delete();
            model_stalls = 0;
            model_flushes = 0;
        end else begin
            if (exp_hazard() && !PCSrc_E) model_stalls = sat(model_stalls + 1);
            if (PCSrc_E) model_flushes = sat(model_flushes + 1);
            hist.push_front('{rd: Rd_E, wr: RegWrite_E});
            if (hist.size() > 2) void'(hist.pop_back());
        end
    endtask

    task automatic assert_reset_now();
        reset = 1'b1;
        hist.delete();
        model_stalls = 0;
        model_flushes = 0;
    endtask

    task automatic next_cycle(input logic [4:0] rs1d, input logic [4:0] rs2d,
                              input logic [4:0] rs1e, input logic [4:0] rs2e,
                              input logic [4:0] rde, input logic rw,
                              input logic [1:0] rsrc, input logic pc);
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
        Rs1_D = rs1d; Rs2_D = rs2d; Rs1_E = rs1e; Rs2_E = rs2e;
        Rd_E = rde; RegWrite_E = rw; ResultSrc_E = rsrc; PCSrc_E = pc;
        @(negedge clk);
        #1;
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        logic       hz, st;
        logic [1:0] fa, fb;
        cycle_no++;
        hz = !reset && exp_hazard();
        st = hz && !PCSrc_E;
        fa = reset ? 2'b00 : exp_fwd(Rs1_E);
        fb = reset ? 2'b00 : exp_fwd(Rs2_E);
        $display("cycle %0d rst=%0b D=%0d,%0d E=%0d,%0d rd=%0d rw=%0b rs=%0d pc=%0b | fa=%0d fb=%0d sf=%0b sd=%0b fd=%0b fe=%0b sc=%0d fc=%0d",
                 cycle_no, reset, Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, RegWrite_E, ResultSrc_E, PCSrc_E,
                 ForwardA_E, ForwardB_E, Stall_F, Stall_D, Flush_D, Flush_E, StallCount, FlushCount);
        chk("ForwardA_E", 32'(ForwardA_E), 32'(fa));
        chk("ForwardB_E", 32'(ForwardB_E), 32'(fb));
        chk("Stall_F", 32'(Stall_F), 32'(st));
        chk("Stall_D", 32'(Stall_D), 32'(st));
        chk("Flush_D", 32'(Flush_D), 32'(!reset && PCSrc_E));
        chk("Flush_E", 32'(Flush_E), 32'(!reset && (hz || PCSrc_E)));
        chk("StallCount", 32'(StallCount), 32'(model_stalls));
        chk("FlushCount", 32'(FlushCount), 32'(model_flushes));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        @(negedge clk);
        #1;
        chk("reset_stall", 32'(Stall_D), 32'd0);
        chk("reset_stallcount", 32'(StallCount), 32'd0);

        // Forwarding: M then W.
        next_cycle(0, 0, 0, 0, 0, 0, 2'b00, 0);
        next_cycle(0, 0, 0, 0, 5, 1, 2'b00, 0);
        next_cycle(0, 0, 5, 0, 0, 0, 2'b00, 0);
        chk("lit_fwdA_M", 32'(ForwardA_E), FWD_EN ? 32'd2 : 32'd0);
        next_cycle(0, 0, 0, 5, 0, 0, 2'b00, 0);
        chk("lit_fwdB_W", 32'(ForwardB_E), FWD_EN ? 32'd1 : 32'd0);

        // Load-use.
        next_cycle(0, 7, 0, 0, 7, 1, 2'b01, 0);
        chk("lit_lu_stallF", 32'(Stall_F), 32'd1);
        chk("lit_lu_stallD", 32'(Stall_D), 32'd1);
        chk("lit_lu_flushE", 32'(Flush_E), 32'd1);
        chk("lit_lu_cnt0", 32'(StallCount), 32'd0);
        next_cycle(0, 7, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_lu_cnt1", 32'(StallCount), 32'd1);
        chk("lit_lu_second", 32'(Stall_D), FWD_EN ? 32'd0 : 32'd1);
        next_cycle(0, 7, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_lu_release", 32'(Stall_D), 32'd0);
        chk("lit_lu_cnt_end", 32'(StallCount), FWD_EN ? 32'd1 : 32'd2);

        // Load to x0 never stalls.
        next_cycle(0, 0, 0, 0, 0, 1, 2'b01, 0);
        chk("lit_x0_nostall", 32'(Stall_D), 32'd0);

        // Redirect together with load-use.
        next_cycle(9, 0, 0, 0, 9, 1, 2'b01, 1);
        chk("lit_br_stallD", 32'(Stall_D), 32'd0);
        chk("lit_br_flushD", 32'(Flush_D), 32'd1);
        chk("lit_br_flushE", 32'(Flush_E), 32'd1);
        next_cycle(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_br_flushcnt", 32'(FlushCount), 32'd1);
        chk("lit_br_stallcnt", 32'(StallCount), FWD_EN ? 32'd1 : 32'd2);

        // ALU producer feeding Decode.
        next_cycle(3, 0, 0, 0, 3, 1, 2'b00, 0);
        chk("lit_alu_1", 32'(Stall_D), FWD_EN ? 32'd0 : 32'd1);
        next_cycle(3, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_alu_2", 32'(Stall_D), FWD_EN ? 32'd0 : 32'd1);
        next_cycle(3, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_alu_3", 32'(Stall_D), 32'd0);

        // Reset in the middle of a stall.
        next_cycle(0, 7, 0, 0, 7, 1, 2'b01, 0);
        chk("lit_pre_rst_stall", 32'(Stall_D), 32'd1);
        assert_reset_now();
        #1;
        chk("lit_rst_stallD", 32'(Stall_D), 32'd0);
        chk("lit_rst_flushE", 32'(Flush_E), 32'd0);
        chk("lit_rst_stallcnt", 32'(StallCount), 32'd0);
        chk("lit_rst_flushcnt", 32'(FlushCount), 32'd0);
        next_cycle(0, 7, 7, 7, 0, 0, 2'b00, 0);
        chk("lit_post_rst_fwdA", 32'(ForwardA_E), 32'd0);
        chk("lit_post_rst_fwdB", 32'(ForwardB_E), 32'd0);
        chk("lit_post_rst_stall", 32'(Stall_D), 32'd0);

        // Saturation of the stall counter.
        for (int i = 0; i < 20; i++) next_cycle(0, 7, 0, 0, 7, 1, 2'b01, 0);
        next_cycle(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("lit_sat_15", 32'(StallCount), 32'd15);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                @(posedge clk);
                model_edge();
                #1;
                assert_reset_now();
                @(negedge clk);
                #1;
            end
            next_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
